tlk2711_tx_engine: RTL and testbench
====================================

Name: tlk2711_tx_engine

Overview:
Parametrised TLK2711 transmit engine, the successor of the fixed-pattern tlk2711 transmitter. Drives the 16-bit TLK2711 parallel TX bus plus its control pins from tx_clk. Adds start/stop sessions, selectable mode (idle-only, counter-pattern frames, user-stream frames, device PRBS), framing with SOF/checksum/EOF and a configurable inter-frame gap. Instantiated in top in place of the existing transmitter; a software-facing register block drives it later.

Parameters:
FRAME_LEN, 256, payload words per frame (1..65535)
IDLE_GAP, 4, idle words between EOF and next SOF (>=1)
CNT_INIT, 16'h0000, first payload word of each counter-pattern frame
FCNT_W, 32, width of frame counter

Ports:
tx_clk  in  1  transmit clock, all logic synchronous to it
rst  in  1  asynchronous active-high reset
i_start  in  1  pulse: begin session with i_mode
i_stop  in  1  pulse: end session at next frame boundary
i_mode  in  2  0 idle, 1 counter frames, 2 stream frames, 3 device PRBS
o_stop_ack  out  1  one-cycle pulse when stopped
o_busy  out  1  session active
s_data  in  16  user payload word
s_valid  in  1  s_data valid
s_ready  out  1  word accepted when s_valid&s_ready
o_txd  out  16  TLK2711 TXD
o_tkmsb / o_tklsb  out  1 each  K-character flags for upper/lower byte
o_loopen, o_prbsen, o_enable, o_lckrefn, o_testen  out  1 each  TLK2711 control pins
o_frame_cnt  out  FCNT_W  frames completed since last start, wraps
o_underrun  out  1  sticky: stream starved mid-frame

Behaviour:
- Reset: clock is tx_clk; reset is asynchronous and active-high (rst). All outputs registered. On reset: o_txd=16'hC5BC (IDLE), tklsb=1, tkmsb=0, o_enable=0, o_lckrefn=1, o_loopen=0, o_prbsen=0, o_testen=0, o_busy=0, o_stop_ack=0, s_ready=0, o_frame_cnt=0, o_underrun=0, state OFF.
- Reset mid-frame: aborts immediately, no EOF sent.
- o_enable rises to 1 the first cycle after reset release and stays 1.
- Code words: IDLE 16'hC5BC (tklsb=1); SOF 16'h50FB (tklsb=1); EOF 16'h50FD (tklsb=1); data words tklsb=tkmsb=0.
- States: OFF, GAP, SOF, PAY, CSUM, EOF, HOLD.
- OFF: emits IDLE. i_start latches i_mode, clears o_frame_cnt and o_underrun, sets o_busy.
  - Modes 1/2 -> GAP.
  - Modes 0/3 -> HOLD. o_prbsen=1 in HOLD for mode 3 only.
- GAP: IDLE for IDLE_GAP cycles -> SOF.
- SOF: one cycle -> PAY. Checksum and payload counter cleared.
- PAY:
  - Mode 1: emits CNT_INIT+k for k=0..FRAME_LEN-1, mod 2^16.
  - Mode 2: s_ready=1. Each accepted word appears on o_txd the next cycle. If s_valid=0, emits IDLE, payload count holds, o_underrun set.
  - After FRAME_LEN payload words -> CSUM.
- CSUM: emits 16-bit sum mod 2^16 of the frame's payload words (data word) -> EOF.
- EOF: emits EOF, increments o_frame_cnt. Then -> OFF with o_stop_ack pulse if stop pending, else -> GAP.
- Stop:
  - i_stop at any time in a session sets stop-pending. It takes effect at EOF in modes 1/2, next cycle in HOLD.
  - On taking effect: o_stop_ack=1 for one cycle, o_busy=0, o_prbsen=0.
  - i_stop in OFF: o_stop_ack pulses the next cycle.
  - i_start and i_stop together in OFF: stop wins, stays OFF.
  - i_start while busy is ignored.
- Latency: state-to-pin 1 cycle; i_start to first IDLE of GAP 1 cycle.
- Invalid parameters (FRAME_LEN=0, IDLE_GAP=0) are rejected by elaboration assertion.

Decomposition:
- Package tlk2711_pkg: K_IDLE, K_SOF, K_EOF constants; mode enum (MODE_IDLE, MODE_CNT, MODE_STREAM, MODE_PRBS); state enum.
- One sub-module tlk2711_tx_word: registered output stage mapping (word, k-flags) to o_txd/o_tkmsb/o_tklsb, reset to IDLE.
- FSM, counters and checksum stay in tlk2711_tx_engine.

Test Plan:
- Reset, then idle 10 cycles -> o_txd=C5BC, tklsb=1, o_enable=1 from cycle 1 after release, o_busy=0.
- FRAME_LEN=4, IDLE_GAP=2, mode 1, CNT_INIT=0 -> 2×IDLE, 50FB, 0000,0001,0002,0003, 0006, 50FD, repeats; o_frame_cnt increments per EOF.
- Mode 2, FRAME_LEN=4, s_valid low for 3 cycles after second word -> 3 IDLE inside payload, o_underrun=1, checksum still the sum of the 4 words.
- i_stop asserted during PAY of frame 1 -> frame completes with EOF, o_stop_ack pulses the next cycle, o_busy=0, IDLE thereafter, o_frame_cnt=1.
- Mode 3 start then stop -> o_prbsen=1 from start+1 until ack, cleared with ack; simultaneous start+stop in OFF -> ack only.
- rst asserted mid-payload -> outputs at reset values asynchronously, no EOF; new session restarts at frame count 0.

Source files
------------

// File: rtl/tlk2711_pkg.sv
// Shared constants and enumerations for the TLK2711 transmit engine.
// K-character code words carry their K flag on the low byte only.
package tlk2711_pkg;

  localparam logic [15:0] K_IDLE = 16'hC5BC;
  localparam logic [15:0] K_SOF  = 16'h50FB;
  localparam logic [15:0] K_EOF  = 16'h50FD;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_CNT    = 2'd1,
    MODE_STREAM = 2'd2,
    MODE_PRBS   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_GAP,
    ST_SOF,
    ST_PAY,
    ST_CSUM,
    ST_EOF,
    ST_HOLD
  } state_e;

  // Counter and stream modes send framed traffic; the others just hold the line.
  function automatic logic is_framed(mode_e m);
    return (m == MODE_CNT) || (m == MODE_STREAM);
  endfunction

endpackage

// File: rtl/tlk2711_tx_engine_if.sv
// User payload stream into the transmit engine (valid/ready handshake).
interface tlk2711_tx_engine_if;

  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/tlk2711_tx_word.sv
// Registered TLK2711 output stage: one word plus its K flags per tx_clk.
module tlk2711_tx_word
  import tlk2711_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] word_i,
  input  logic        kmsb_i,
  input  logic        klsb_i,
  output logic [15:0] txd_o,
  output logic        tkmsb_o,
  output logic        tklsb_o
);

  logic [15:0] txd_q;
  logic        tkmsb_q;
  logic        tklsb_q;

  // Reset parks the link on IDLE so the far end never sees a torn frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd_q   <= K_IDLE;
      tkmsb_q <= 1'b0;
      tklsb_q <= 1'b1;
    end else begin
      txd_q   <= word_i;
      tkmsb_q <= kmsb_i;
      tklsb_q <= klsb_i;
    end
  end

  assign txd_o   = txd_q;
  assign tkmsb_o = tkmsb_q;
  assign tklsb_o = tklsb_q;

endmodule

// File: rtl/tlk2711_tx_engine.sv
// TLK2711 transmit engine: session control, SOF/payload/checksum/EOF framing,
// inter-frame gap and device PRBS hand-off, driving the TX pins from tx_clk.
module tlk2711_tx_engine
  import tlk2711_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned IDLE_GAP  = 4,
  parameter logic [15:0] CNT_INIT  = 16'h0000,
  parameter int unsigned FCNT_W    = 32
) (
  input  logic              tx_clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  output logic              o_stop_ack,
  output logic              o_busy,
  tlk2711_tx_engine_if.slave s_if,
  output logic [15:0]       o_txd,
  output logic              o_tkmsb,
  output logic              o_tklsb,
  output logic              o_loopen,
  output logic              o_prbsen,
  output logic              o_enable,
  output logic              o_lckrefn,
  output logic              o_testen,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic              o_underrun
);

  if (FRAME_LEN == 0 || FRAME_LEN > 65535) begin : g_bad_frame_len
    $error("tlk2711_tx_engine: FRAME_LEN must be in 1..65535");
  end
  if (IDLE_GAP == 0 || IDLE_GAP > 65536) begin : g_bad_idle_gap
    $error("tlk2711_tx_engine: IDLE_GAP must be in 1..65536");
  end

  localparam logic [15:0] PAY_LAST = 16'(FRAME_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(IDLE_GAP - 1);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic                stop_pend_q, stop_pend_d;
  logic                stop_ack_q, stop_ack_d;
  logic                busy_q, busy_d;
  logic                prbsen_q, prbsen_d;
  logic                enable_q;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                underrun_q, underrun_d;
  logic [15:0]         gap_cnt_q, gap_cnt_d;
  logic [15:0]         pay_cnt_q, pay_cnt_d;
  logic [15:0]         csum_q, csum_d;
  logic                s_ready_q, s_ready_d;
  logic [15:0]         word_d;
  logic                klsb_d;
  logic                stop_req;
  mode_e               start_mode;

  assign start_mode = mode_e'(i_mode);

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OFF;
      mode_q      <= MODE_IDLE;
      stop_pend_q <= 1'b0;
      stop_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      prbsen_q    <= 1'b0;
      enable_q    <= 1'b0;
      frame_cnt_q <= '0;
      underrun_q  <= 1'b0;
      gap_cnt_q   <= '0;
      pay_cnt_q   <= '0;
      csum_q      <= '0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      stop_pend_q <= stop_pend_d;
      stop_ack_q  <= stop_ack_d;
      busy_q      <= busy_d;
      prbsen_q    <= prbsen_d;
      enable_q    <= 1'b1;
      frame_cnt_q <= frame_cnt_d;
      underrun_q  <= underrun_d;
      gap_cnt_q   <= gap_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      csum_q      <= csum_d;
      s_ready_q   <= s_ready_d;
    end
  end

  // word_d is the word for the current state; the output stage puts it on the pins next cycle.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    stop_pend_d = stop_pend_q;
    stop_ack_d  = 1'b0;
    busy_d      = busy_q;
    prbsen_d    = prbsen_q;
    frame_cnt_d = frame_cnt_q;
    underrun_d  = underrun_q;
    gap_cnt_d   = gap_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    csum_d      = csum_q;
    word_d      = K_IDLE;
    klsb_d      = 1'b1;
    stop_req    = i_stop | stop_pend_q;

    if (i_stop) stop_pend_d = 1'b1;

    case (state_q)
      ST_OFF: begin
        stop_pend_d = 1'b0;
        if (stop_req) begin
          stop_ack_d = 1'b1;
          busy_d     = 1'b0;
          prbsen_d   = 1'b0;
        end else if (i_start) begin
          mode_d      = start_mode;
          busy_d      = 1'b1;
          frame_cnt_d = '0;
          underrun_d  = 1'b0;
          if (is_framed(start_mode)) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d  = ST_HOLD;
            prbsen_d = (start_mode == MODE_PRBS);
          end
        end
      end
      ST_HOLD: begin
        if (stop_req) begin
          state_d     = ST_OFF;
          stop_pend_d = 1'b0;
          stop_ack_d  = 1'b1;
          busy_d      = 1'b0;
          prbsen_d    = 1'b0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_SOF;
        else gap_cnt_d = gap_cnt_q + 16'd1;
      end
      ST_SOF: begin
        word_d    = K_SOF;
        csum_d    = '0;
        pay_cnt_d = '0;
        state_d   = ST_PAY;
      end
      ST_PAY: begin
        if (mode_q == MODE_STREAM && !(s_if.s_valid && s_ready_q)) begin
          underrun_d = 1'b1;
        end else begin
          word_d = (mode_q == MODE_STREAM) ? s_if.s_data : CNT_INIT + pay_cnt_q;
          klsb_d = 1'b0;
          csum_d = csum_q + word_d;
          if (pay_cnt_q == PAY_LAST) state_d = ST_CSUM;
          else pay_cnt_d = pay_cnt_q + 16'd1;
        end
      end
      ST_CSUM: begin
        word_d  = csum_q;
        klsb_d  = 1'b0;
        state_d = ST_EOF;
      end
      ST_EOF: begin
        word_d      = K_EOF;
        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        // A pending stop stays set so OFF issues the ack one cycle after EOF.
        if (stop_req) begin
          state_d = ST_OFF;
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      default: state_d = ST_OFF;
    endcase

    s_ready_d = (state_d == ST_PAY) && (mode_d == MODE_STREAM);
  end

  tlk2711_tx_word u_word (
    .clk     (tx_clk),
    .rst     (rst),
    .word_i  (word_d),
    .kmsb_i  (1'b0),
    .klsb_i  (klsb_d),
    .txd_o   (o_txd),
    .tkmsb_o (o_tkmsb),
    .tklsb_o (o_tklsb)
  );

  assign s_if.s_ready = s_ready_q;
  assign o_stop_ack   = stop_ack_q;
  assign o_busy       = busy_q;
  assign o_prbsen     = prbsen_q;
  assign o_enable     = enable_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_underrun   = underrun_q;
  assign o_loopen     = 1'b0;
  assign o_lckrefn    = 1'b1;
  assign o_testen     = 1'b0;

endmodule

// File: tb/tb_tlk2711_tx_engine.sv
// Directed-vector bench for tlk2711_tx_engine (FRAME_LEN=4, IDLE_GAP=2, CNT_INIT=0).
module tb_tlk2711_tx_engine;

  typedef struct {
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] sdata;
    logic        sv;
    logic [15:0] txd;
    logic        klsb;
    logic        busy;
    logic        ack;
    logic [31:0] fc;
    logic        prb;
    logic        und;
    logic        rdy;
  } vec_t;

  localparam int I = 32'hC5BC;
  localparam int S = 32'h50FB;
  localparam int E = 32'h50FD;

  logic        tx_clk = 1'b0;
  logic        rst;
  logic        i_start, i_stop;
  logic [1:0]  i_mode;
  logic        o_stop_ack, o_busy;
  logic [15:0] o_txd;
  logic        o_tkmsb, o_tklsb, o_loopen, o_prbsen, o_enable, o_lckrefn, o_testen;
  logic [31:0] o_frame_cnt;
  logic        o_underrun;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  tlk2711_tx_engine_if sBus ();

  tlk2711_tx_engine #(
    .FRAME_LEN (4),
    .IDLE_GAP  (2),
    .CNT_INIT  (16'h0000),
    .FCNT_W    (32)
  ) dut (
    .tx_clk      (tx_clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_mode      (i_mode),
    .o_stop_ack  (o_stop_ack),
    .o_busy      (o_busy),
    .s_if        (sBus),
    .o_txd       (o_txd),
    .o_tkmsb     (o_tkmsb),
    .o_tklsb     (o_tklsb),
    .o_loopen    (o_loopen),
    .o_prbsen    (o_prbsen),
    .o_enable    (o_enable),
    .o_lckrefn   (o_lckrefn),
    .o_testen    (o_testen),
    .o_frame_cnt (o_frame_cnt),
    .o_underrun  (o_underrun)
  );

  always #5 tx_clk = ~tx_clk;

  function automatic vec_t v(input int st, sp, md, sd, sv, txd, k, bsy, ack, fc, prb, und, rdy);
    vec_t r;
    r.start = st[0];  r.stop = sp[0];  r.mode = md[1:0];  r.sdata = sd[15:0];  r.sv = sv[0];
    r.txd = txd[15:0];  r.klsb = k[0];  r.busy = bsy[0];  r.ack = ack[0];  r.fc = fc;
    r.prb = prb[0];  r.und = und[0];  r.rdy = rdy[0];
    return r;
  endfunction

  task automatic cmp(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t r);
    @(negedge tx_clk);
    i_start = r.start;
    i_stop = r.stop;
    i_mode = r.mode;
    sBus.s_data = r.sdata;
    sBus.s_valid = r.sv;
    @(posedge tx_clk);
    #1;
  endtask

  task automatic checkOutput(input int row, input vec_t r);
    cmp("txd", row, 32'(o_txd), 32'(r.txd));
    cmp("tklsb", row, 32'(o_tklsb), 32'(r.klsb));
    cmp("tkmsb", row, 32'(o_tkmsb), 32'd0);
    cmp("busy", row, 32'(o_busy), 32'(r.busy));
    cmp("stop_ack", row, 32'(o_stop_ack), 32'(r.ack));
    cmp("frame_cnt", row, o_frame_cnt, r.fc);
    cmp("prbsen", row, 32'(o_prbsen), 32'(r.prb));
    cmp("underrun", row, 32'(o_underrun), 32'(r.und));
    cmp("s_ready", row, 32'(sBus.s_ready), 32'(r.rdy));
    cmp("enable", row, 32'(o_enable), 32'd1);
  endtask

  initial begin
    vec_t idle;
    rst = 1'b1;
    i_start = 1'b0;
    i_stop = 1'b0;
    i_mode = 2'd0;
    sBus.s_data = 16'h0;
    sBus.s_valid = 1'b0;
    idle = v(0,0,0,0,0, I,1,0,0,0,0,0,0);

    // Session A: counter frames, start ignored while busy, stop during frame 2 payload.
    vecs.push_back(v(1,0,1,0,0, I,1,1,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,1,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,1,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, S,1,1,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, 'h0000,0,1,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, 'h0001,0,1,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, 'h0002,0,1,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, 'h0003,0,1,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, 'h0006,0,1,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, E,1,1,0,1,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,1,0,1,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,1,0,1,0,0,0));
    vecs.push_back(v(0,0,0,0,0, S,1,1,0,1,0,0,0));
    vecs.push_back(v(0,0,0,0,0, 'h0000,0,1,0,1,0,0,0));
    vecs.push_back(v(1,0,2,0,0, 'h0001,0,1,0,1,0,0,0));
    vecs.push_back(v(0,1,0,0,0, 'h0002,0,1,0,1,0,0,0));
    vecs.push_back(v(0,0,0,0,0, 'h0003,0,1,0,1,0,0,0));
    vecs.push_back(v(0,0,0,0,0, 'h0006,0,1,0,1,0,0,0));
    vecs.push_back(v(0,0,0,0,0, E,1,1,0,2,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,0,1,2,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,0,0,2,0,0,0));
    // Session B: stream frame with a 3-cycle starvation and a stop during payload.
    vecs.push_back(v(1,0,2,0,0, I,1,1,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,1,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,1,0,0,0,0,0));
    vecs.push_back(v(0,0,0,'hDEAD,1, S,1,1,0,0,0,0,1));
    vecs.push_back(v(0,0,0,'h1111,1, 'h1111,0,1,0,0,0,0,1));
    vecs.push_back(v(0,1,0,'h2222,1, 'h2222,0,1,0,0,0,0,1));
    vecs.push_back(v(0,0,0,0,0, I,1,1,0,0,0,1,1));
    vecs.push_back(v(0,0,0,0,0, I,1,1,0,0,0,1,1));
    vecs.push_back(v(0,0,0,0,0, I,1,1,0,0,0,1,1));
    vecs.push_back(v(0,0,0,'h3333,1, 'h3333,0,1,0,0,0,1,1));
    vecs.push_back(v(0,0,0,'h4444,1, 'h4444,0,1,0,0,0,1,0));
    vecs.push_back(v(0,0,0,0,0, 'hAAAA,0,1,0,0,0,1,0));
    vecs.push_back(v(0,0,0,0,0, E,1,1,0,1,0,1,0));
    vecs.push_back(v(0,0,0,0,0, I,1,0,1,1,0,1,0));
    vecs.push_back(v(0,0,0,0,0, I,1,0,0,1,0,1,0));
    // Session C: device PRBS; session D: idle-only; then start+stop and bare stop in OFF.
    vecs.push_back(v(1,0,3,0,0, I,1,1,0,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,1,0,0,1,0,0));
    vecs.push_back(v(0,1,0,0,0, I,1,0,1,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,0,0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0, I,1,1,0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0, I,1,0,1,0,0,0,0));
    vecs.push_back(v(1,1,1,0,0, I,1,0,1,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,0,0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0, I,1,0,1,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0, I,1,0,0,0,0,0,0));

    repeat (3) @(posedge tx_clk);
    #1;
    cmp("rst txd", -1, 32'(o_txd), 32'hC5BC);
    cmp("rst tklsb", -1, 32'(o_tklsb), 32'd1);
    cmp("rst enable", -1, 32'(o_enable), 32'd0);
    cmp("rst lckrefn", -1, 32'(o_lckrefn), 32'd1);
    cmp("rst loopen", -1, 32'(o_loopen), 32'd0);
    cmp("rst testen", -1, 32'(o_testen), 32'd0);
    cmp("rst prbsen", -1, 32'(o_prbsen), 32'd0);
    cmp("rst busy", -1, 32'(o_busy), 32'd0);
    cmp("rst s_ready", -1, 32'(sBus.s_ready), 32'd0);

    @(negedge tx_clk);
    rst = 1'b0;
    @(posedge tx_clk);
    #1;
    cmp("enable after release", -1, 32'(o_enable), 32'd1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(idle);
      checkOutput(1000 + i, idle);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Replay session A into frame 2 payload, then reset asynchronously mid-frame.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(2000 + i, vecs[i]);
    end
    @(negedge tx_clk);
    #1;
    rst = 1'b1;
    #1;
    cmp("async rst txd", -1, 32'(o_txd), 32'hC5BC);
    cmp("async rst tklsb", -1, 32'(o_tklsb), 32'd1);
    cmp("async rst busy", -1, 32'(o_busy), 32'd0);
    cmp("async rst frame_cnt", -1, o_frame_cnt, 32'd0);
    cmp("async rst enable", -1, 32'(o_enable), 32'd0);
    repeat (3) begin
      @(posedge tx_clk);
      #1;
      cmp("held rst txd", -1, 32'(o_txd), 32'hC5BC);
    end
    @(negedge tx_clk);
    rst = 1'b0;
    @(posedge tx_clk);
    #1;
    cmp("enable after second release", -1, 32'(o_enable), 32'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(3000 + i, vecs[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
